// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables (1-based DES bit numbers), per-round
// rotation amounts for both stream orders, FSM state type and rotate helpers.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic {IDLE, EMIT} state_e;

  // Entry j names the key bit that lands in PC-1 output bit j+1 (first 28 = C, rest = D).
  localparam int PC1_TBL [2*CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry i = rotation applied before the (i+1)-th subkey of the stream.
  localparam logic [1:0] ENC_ROT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };
  localparam logic [1:0] DEC_ROT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // DES left rotation moves bit 1 (index 0) towards bit 28 (index 27).
  function automatic logic [CD_W-1:0] rot_left(input logic [CD_W-1:0] v, input logic [1:0] amt);
    case (amt)
      2'd1:    rot_left = {v[0], v[CD_W-1:1]};
      2'd2:    rot_left = {v[1:0], v[CD_W-1:2]};
      default: rot_left = v;
    endcase
  endfunction

  function automatic logic [CD_W-1:0] rot_right(input logic [CD_W-1:0] v, input logic [1:0] amt);
    case (amt)
      2'd1:    rot_right = {v[CD_W-2:0], v[CD_W-1]};
      2'd2:    rot_right = {v[CD_W-3:0], v[CD_W-1:CD_W-2]};
      default: rot_right = v;
    endcase
  endfunction

endpackage

// File: rtl/des_pc1_permutation.sv
// PC-1: drops the eight parity bits and reorders the key into {D0, C0}; purely combinational.
module des_pc1_permutation
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]  key_i,
  output logic [2*CD_W-1:0] cd_o
);

  for (genvar j = 0; j < 2*CD_W; j++) begin : g_pc1
    localparam int SRC = PC1_TBL[j] - 1;
    assign cd_o[j] = key_i[SRC];
  end

  logic parity_unused;
  assign parity_unused = ^{key_i[63], key_i[55], key_i[47], key_i[39],
                           key_i[31], key_i[23], key_i[15], key_i[7]};

endmodule

// File: rtl/des_key_schedule.sv
// Streams the 16 DES round subkeys of one key over valid/ready; first subkey one cycle after load,
// then one per handshake. Stalled subkeys hold stable and the C/D registers do not rotate.
module des_key_schedule
  import des_pkg::*;
#(
  parameter bit ALLOW_RESTART = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [KEY_W-1:0]    i_key,
  input  logic                i_decrypt,
  input  logic                i_subkey_ready,
  output logic                o_busy,
  output logic                o_subkey_valid,
  output logic [SUBKEY_W-1:0] o_subkey,
  output logic [3:0]          o_round,
  output logic                o_last,
  output logic                o_done
);

  state_e            state_q, state_d;
  logic [CD_W-1:0]   c_q, c_d, d_q, d_d;
  logic [3:0]        count_q, count_d;
  logic              decrypt_q, decrypt_d;
  logic              done_q, done_d;
  logic [2*CD_W-1:0] pc1_cd, cd;
  logic [CD_W-1:0]   pc1_c, pc1_d;
  logic [3:0]        next_idx;
  logic              emit, hs, last_hs, load;

  des_pc1_permutation u_pc1 (
    .key_i (i_key),
    .cd_o  (pc1_cd)
  );

  assign pc1_c    = pc1_cd[CD_W-1:0];
  assign pc1_d    = pc1_cd[2*CD_W-1:CD_W];
  assign cd       = {d_q, c_q};
  assign emit     = (state_q == EMIT);
  assign hs       = emit & i_subkey_ready;
  assign last_hs  = hs & (count_q == 4'd15);
  assign load     = i_start & (~emit | ALLOW_RESTART);
  assign next_idx = count_q + 4'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = EMIT;
      EMIT:    if (load) state_d = EMIT;
               else if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      c_q       <= '0;
      d_q       <= '0;
      count_q   <= 4'd0;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      c_q       <= c_d;
      d_q       <= d_d;
      count_q   <= count_d;
      decrypt_q <= decrypt_d;
      done_q    <= done_d;
    end
  end

  // A reload wins over a same-cycle handshake, so an aborted stream never reports done.
  always_comb begin
    c_d       = c_q;
    d_d       = d_q;
    count_d   = count_q;
    decrypt_d = decrypt_q;
    done_d    = last_hs & ~load;
    if (load) begin
      decrypt_d = i_decrypt;
      count_d   = 4'd0;
      if (i_decrypt) begin
        c_d = rot_right(pc1_c, DEC_ROT[0]);
        d_d = rot_right(pc1_d, DEC_ROT[0]);
      end else begin
        c_d = rot_left(pc1_c, ENC_ROT[0]);
        d_d = rot_left(pc1_d, ENC_ROT[0]);
      end
    end else if (hs) begin
      count_d = next_idx;
      if (!last_hs) begin
        if (decrypt_q) begin
          c_d = rot_right(c_q, DEC_ROT[next_idx]);
          d_d = rot_right(d_q, DEC_ROT[next_idx]);
        end else begin
          c_d = rot_left(c_q, ENC_ROT[next_idx]);
          d_d = rot_left(d_q, ENC_ROT[next_idx]);
        end
      end
    end
  end

  for (genvar k = 0; k < SUBKEY_W; k++) begin : g_pc2
    localparam int SRC = PC2_TBL[k] - 1;
    assign o_subkey[k] = cd[SRC];
  end

  always_comb begin
    o_busy         = emit;
    o_subkey_valid = emit;
    o_last         = emit & (count_q == 4'd15);
    o_round        = decrypt_q ? (4'd15 - count_q) : count_q;
    o_done         = done_q;
  end

endmodule
